// File: rtl/taxi_eth_stat_pkg.sv
// Shared types for the MAC statistics accumulator: op codes, FSM states and
// the pipeline stage record.
package taxi_eth_stat_pkg;

  localparam int STAT_ID_W  = 8;
  localparam int STAT_INC_W = 16;

  typedef enum logic [1:0] {
    OP_UPD,
    OP_RD,
    OP_RD_CLR
  } stat_op_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } stat_state_t;

  // Stage field widths follow the package constants, which the top-level
  // parameters default to.
  typedef struct packed {
    logic                  valid;
    stat_op_t              op;
    logic [STAT_ID_W-1:0]  id;
    logic [STAT_INC_W-1:0] inc;
  } stat_stage_t;

endpackage

// File: rtl/taxi_eth_stat_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array is never reset; the owner clears it with an init sweep.
module taxi_eth_stat_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/taxi_eth_stat_counter.sv
// 64-bit statistics counters in RAM, fed by the MAC stat stream, with a host
// read/clear-on-read port. Three-stage issue/read/modify-write pipeline.
module taxi_eth_stat_counter
  import taxi_eth_stat_pkg::*;
#(
  parameter int INC_W = STAT_INC_W,
  parameter int ID_W  = STAT_ID_W,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] s_axis_stat_tdata,
  input  logic [ID_W-1:0]  s_axis_stat_tid,
  input  logic             s_axis_stat_tuser,
  input  logic             s_axis_stat_tvalid,
  output logic             s_axis_stat_tready,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [ID_W-1:0]  rd_req_addr,
  input  logic             rd_req_clear,
  output logic             rd_resp_valid,
  output logic [CNT_W-1:0] rd_resp_data,
  output logic             init_done,
  output stat_state_t      o_dbg_state
);

  // Handshake: a stat beat or host request transfers on a clock edge where
  // its valid and ready are both high; rd_resp_valid is a one-cycle pulse.

  stat_state_t r_state, w_state_next;
  logic [ID_W-1:0] r_init_ptr;

  stat_stage_t w_iss, r_s1, r_s2;
  logic [CNT_W-1:0] r_s2_old, w_s1_old, w_s2_wdata, w_ram_rdata;
  logic             w_s2_wr, w_run;
  logic             r_fwd_valid;
  logic [ID_W-1:0]  r_fwd_id;
  logic [CNT_W-1:0] r_fwd_data;

  logic             w_ram_we;
  logic [ID_W-1:0]  w_ram_waddr;
  logic [CNT_W-1:0] w_ram_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + ID_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_ptr == '1) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  assign w_run              = (r_state == ST_RUN);
  assign init_done          = w_run;
  assign o_dbg_state        = r_state;
  assign rd_req_ready       = w_run;
  assign s_axis_stat_tready = w_run && !rd_req_valid;

  // Host reads win the single issue slot; tuser beats are swallowed.
  always_comb begin
    w_iss = '0;
    if (w_run && rd_req_valid) begin
      w_iss.valid = 1'b1;
      w_iss.op    = rd_req_clear ? OP_RD_CLR : OP_RD;
      w_iss.id    = rd_req_addr;
    end else if (w_run && s_axis_stat_tvalid && !s_axis_stat_tuser) begin
      w_iss.valid = 1'b1;
      w_iss.op    = OP_UPD;
      w_iss.id    = s_axis_stat_tid;
      w_iss.inc   = s_axis_stat_tdata;
    end
  end

  assign w_s2_wr    = r_s2.valid && (r_s2.op != OP_RD);
  assign w_s2_wdata = (r_s2.op == OP_UPD) ? (r_s2_old + CNT_W'(r_s2.inc)) : '0;

  // Newest value wins: the write happening now, then the write that landed
  // on the same edge as our RAM read, then the RAM itself.
  always_comb begin
    w_s1_old = w_ram_rdata;
    if (r_fwd_valid && (r_fwd_id == r_s1.id)) w_s1_old = r_fwd_data;
    if (w_s2_wr && (r_s2.id == r_s1.id))      w_s1_old = w_s2_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s2_old    <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_id    <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_s1        <= w_iss;
      r_s2        <= r_s1;
      if (r_s1.valid) r_s2_old <= w_s1_old;
      r_fwd_valid <= w_s2_wr;
      r_fwd_id    <= r_s2.id;
      r_fwd_data  <= w_s2_wdata;
    end
  end

  assign rd_resp_valid = r_s2.valid && (r_s2.op != OP_UPD);
  assign rd_resp_data  = r_s2_old;

  assign w_ram_we    = (r_state == ST_INIT) || w_s2_wr;
  assign w_ram_waddr = (r_state == ST_INIT) ? r_init_ptr : r_s2.id;
  assign w_ram_wdata = (r_state == ST_INIT) ? '0 : w_s2_wdata;

  taxi_eth_stat_ram #(
    .ADDR_W(ID_W),
    .DATA_W(CNT_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_waddr(w_ram_waddr),
    .i_wdata(w_ram_wdata),
    .i_raddr(w_iss.id),
    .o_rdata(w_ram_rdata)
  );

endmodule

// File: tb/tb_taxi_eth_stat_counter.sv
// Directed bench for the statistics counter: init sweep, updates, forwarding,
// clear-on-read, wrap, read priority and async reset.
module tb_taxi_eth_stat_counter;
  import taxi_eth_stat_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] s_axis_stat_tdata;
  logic [7:0]  s_axis_stat_tid;
  logic        s_axis_stat_tuser;
  logic        s_axis_stat_tvalid;
  logic        s_axis_stat_tready;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [7:0]  rd_req_addr;
  logic        rd_req_clear;
  logic        rd_resp_valid;
  logic [63:0] rd_resp_data;
  logic        init_done;
  stat_state_t o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_cyc_q[$];

  taxi_eth_stat_counter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_stat_tdata (s_axis_stat_tdata),
    .s_axis_stat_tid   (s_axis_stat_tid),
    .s_axis_stat_tuser (s_axis_stat_tuser),
    .s_axis_stat_tvalid(s_axis_stat_tvalid),
    .s_axis_stat_tready(s_axis_stat_tready),
    .rd_req_valid      (rd_req_valid),
    .rd_req_ready      (rd_req_ready),
    .rd_req_addr       (rd_req_addr),
    .rd_req_clear      (rd_req_clear),
    .rd_resp_valid     (rd_resp_valid),
    .rd_resp_data      (rd_resp_data),
    .init_done         (init_done),
    .o_dbg_state       (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every response is matched against the queued value and cycle.
  always @(negedge clk) begin
    if (rst_n && rd_resp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        check_eq("resp_data", rd_resp_data, exp_q.pop_front());
        check_eq("resp_cycle", 64'(cyc), exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; applies inputs for one cycle, returns at next negedge.
  task automatic drive(input bit rv, input logic [7:0] ra, input bit rc,
                       input logic [63:0] rexp, input bit sv,
                       input logic [7:0] sid, input logic [15:0] sd, input bit su);
    rd_req_valid       = rv;
    rd_req_addr        = ra;
    rd_req_clear       = rc;
    s_axis_stat_tvalid = sv;
    s_axis_stat_tid    = sid;
    s_axis_stat_tdata  = sd;
    s_axis_stat_tuser  = su;
    if (rv) begin
      exp_q.push_back(rexp);
      exp_cyc_q.push_back(64'(cyc + 2));
    end
    @(negedge clk);
  endtask

  task automatic upd(input logic [7:0] id, input logic [15:0] inc);
    drive(0, 8'd0, 0, 64'd0, 1, id, inc, 0);
  endtask

  task automatic rd(input logic [7:0] id, input bit clr, input logic [63:0] exp);
    drive(1, id, clr, exp, 0, 8'd0, 16'd0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'd0, 0, 64'd0, 0, 8'd0, 16'd0, 0);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    check_eq(tag, 64'(init_done), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    rd_req_valid = 0; rd_req_addr = 0; rd_req_clear = 0;
    s_axis_stat_tvalid = 0; s_axis_stat_tid = 0; s_axis_stat_tdata = 0; s_axis_stat_tuser = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    check_eq("rst_tready", 64'(s_axis_stat_tready), 64'd0);
    check_eq("rst_req_ready", 64'(rd_req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
    check_eq("rst_resp_data", rd_resp_data, 64'd0);
    check_eq("rst_state", 64'(o_dbg_state), 64'(ST_INIT));

    // init sweep: exactly 256 edges after release
    rst_n = 1'b1;
    repeat (255) @(negedge clk);
    check_eq("init_at_255", 64'(init_done), 64'd0);
    @(negedge clk);
    check_eq("init_at_256", 64'(init_done), 64'd1);
    check_eq("run_state", 64'(o_dbg_state), 64'(ST_RUN));
    check_eq("run_tready", 64'(s_axis_stat_tready), 64'd1);
    check_eq("run_req_ready", 64'(rd_req_ready), 64'd1);

    rd(8'd0, 0, 64'd0);
    rd(8'd17, 0, 64'd0);
    rd(8'd255, 0, 64'd0);

    // single updates and a discarded tuser beat
    upd(8'd5, 16'd100);
    upd(8'd5, 16'd23);
    rd(8'd5, 0, 64'd123);
    drive(0, 8'd0, 0, 64'd0, 1, 8'd5, 16'd999, 1);
    rd(8'd5, 0, 64'd123);

    // back-to-back forwarding with an interleaved read
    for (int i = 0; i < 4; i++) upd(8'd3, 16'hFFFF);
    rd(8'd3, 0, 64'h3FFFC);
    for (int i = 0; i < 6; i++) upd(8'd3, 16'hFFFF);
    rd(8'd3, 0, 64'h9FFF6);

    // clear-on-read immediately followed by an update
    upd(8'd9, 16'd50);
    rd(8'd9, 1, 64'd50);
    upd(8'd9, 16'd7);
    rd(8'd9, 0, 64'd7);
    idle(3);

    // wrap: preload id 1 through the RAM array while the pipeline is idle
    dut.u_ram.r_mem[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    upd(8'd1, 16'd5);
    rd(8'd1, 0, 64'd3);
    idle(3);

    // read priority: beat held while four host reads go through
    begin
      logic [7:0]  ids [4];
      logic [63:0] vals[4];
      ids  = '{8'd5, 8'd3, 8'd9, 8'd1};
      vals = '{64'd123, 64'h9FFF6, 64'd7, 64'd3};
      for (int i = 0; i < 4; i++) begin
        rd_req_valid = 1; rd_req_addr = ids[i]; rd_req_clear = 0;
        s_axis_stat_tvalid = 1; s_axis_stat_tid = 8'd2; s_axis_stat_tdata = 16'd7; s_axis_stat_tuser = 0;
        exp_q.push_back(vals[i]);
        exp_cyc_q.push_back(64'(cyc + 2));
        #1;
        check_eq("prio_tready_low", 64'(s_axis_stat_tready), 64'd0);
        @(negedge clk);
      end
      rd_req_valid = 0;
      #1;
      check_eq("prio_tready_high", 64'(s_axis_stat_tready), 64'd1);
      @(negedge clk);
      rd(8'd2, 0, 64'd7);
      idle(3);
    end

    // async reset in the middle of a burst with a response on the wire
    upd(8'd4, 16'd1);
    rd(8'd4, 0, 64'd1);
    drive(1, 8'd4, 0, 64'd1, 1, 8'd4, 16'd1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    check_eq("mid_rst_resp_valid", 64'(rd_resp_valid), 64'd0);
    check_eq("mid_rst_resp_data", rd_resp_data, 64'd0);
    check_eq("mid_rst_init_done", 64'(init_done), 64'd0);
    check_eq("mid_rst_tready", 64'(s_axis_stat_tready), 64'd0);
    check_eq("mid_rst_req_ready", 64'(rd_req_ready), 64'd0);
    rd_req_valid = 0; s_axis_stat_tvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reinit_state", 64'(o_dbg_state), 64'(ST_INIT));
    wait_init("reinit_done");
    rd(8'd4, 0, 64'd0);
    rd(8'd5, 0, 64'd0);
    rd(8'd3, 0, 64'd0);
    rd(8'd1, 0, 64'd0);

    // drain outstanding responses
    idle(1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check_eq("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
